// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit that feeds the HI/LO registers.
// It runs MULT/MULTU as a shift-add and DIV/DIVU as a restoring division.
// Each operation takes DATA_W iterations, one per clock.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   start, op, a, b   - operation request; op/a/b are captured when start=1 and busy=0
//                       (op: 00=MULT, 01=MULTU, 10=DIV, 11=DIVU)
//   busy              - an operation is in flight (CALC or DONE)
//   done, hi_w, lo_w  - single-cycle completion / HI and LO write strobes
//   hi_in, lo_in      - product high/low halves, or remainder/quotient;
//                       these hold their value until the next completion
module muldiv_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic              hi_w,
  output logic              lo_w,
  output logic [DATA_W-1:0] hi_in,
  output logic [DATA_W-1:0] lo_in
);

  localparam int unsigned          CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic              is_div;
  logic              neg_a, neg_b, b_zero;
  logic [DATA_W-1:0] mag_a, mag_b;
  // Shared datapath. For a multiply, acc_hi/acc_lo form the running product
  // and acc_lo starts out holding the multiplier. For a divide, acc_hi is the
  // partial remainder and acc_lo shifts the dividend out as the quotient
  // shifts in.
  logic [DATA_W-1:0] acc_hi, acc_lo;

  logic [DATA_W-1:0] abs_a, abs_b;
  logic              last_iter;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   rem_sh;
  logic              rem_fits;
  logic [DATA_W-1:0] rem_diff;
  logic [DATA_W-1:0] hi_step, lo_step;
  logic [DATA_W-1:0] res_hi, res_lo;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
    hi_w = (state == DONE);
    lo_w = (state == DONE);
  end

  always_comb begin
    abs_a     = (~op[0] & a[DATA_W-1]) ? -a : a;
    abs_b     = (~op[0] & b[DATA_W-1]) ? -b : b;
    last_iter = (state == CALC) && (count == LAST_CNT);
  end

  // One iteration of whichever algorithm is running
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
    rem_sh   = {acc_hi, acc_lo[DATA_W-1]};
    // rem_sh is 33 bits wide. A set top bit means the divisor always fits.
    // When the divisor fits, the difference is below 2^DATA_W, so the low
    // bits hold the exact new remainder.
    rem_fits = rem_sh[DATA_W] | (rem_sh[DATA_W-1:0] >= mag_b);
    rem_diff = rem_sh[DATA_W-1:0] - mag_b;
    if (!is_div) begin
      hi_step = mul_sum[DATA_W:1];
      lo_step = {mul_sum[0], acc_lo[DATA_W-1:1]};
    end else if (rem_fits) begin
      hi_step = rem_diff;
      lo_step = {acc_lo[DATA_W-2:0], 1'b1};
    end else begin
      hi_step = rem_sh[DATA_W-1:0];
      lo_step = {acc_lo[DATA_W-2:0], 1'b0};
    end
  end

  // Sign correction of the final iteration's result
  always_comb begin
    res_hi = hi_step;
    res_lo = lo_step;
    if (!is_div) begin
      if (neg_a ^ neg_b) {res_hi, res_lo} = -{hi_step, lo_step};
    end else begin
      res_lo = (neg_a ^ neg_b) ? -lo_step : lo_step;
      res_hi = neg_a ? -hi_step : hi_step;
      // Dividing by zero already gives remainder = |a|. After the sign fix
      // that equals the original a, so only the quotient needs forcing.
      if (b_zero) res_lo = '1;
    end
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_in  <= '0;
      lo_in  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            neg_a  <= ~op[0] & a[DATA_W-1];
            neg_b  <= ~op[0] & b[DATA_W-1];
            b_zero <= (b == '0);
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            count  <= '0;
            acc_hi <= '0;
            acc_lo <= op[1] ? abs_a : abs_b;
          end
        end
        CALC: begin
          acc_hi <= hi_step;
          acc_lo <= lo_step;
          count  <= count + 1'b1;
          if (last_iter) begin
            hi_in <= res_hi;
            lo_in <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int DW  = 32;
  localparam int LAT = 33;   // start edge to the cycle where done is high

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op_i = 2'b00;
  logic [DW-1:0] a_i = '0;
  logic [DW-1:0] b_i = '0;
  logic          busy, done, hi_w, lo_w;
  logic [DW-1:0] hi_in, lo_in;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op_i),
    .a     (a_i),
    .b     (b_i),
    .busy  (busy),
    .done  (done),
    .hi_w  (hi_w),
    .lo_w  (lo_w),
    .hi_in (hi_in),
    .lo_in (lo_in)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {HI, LO} from plain arithmetic on the architectural values
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sp;
    int     sa, sb;
    case (op)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sa = $signed(a);
        sb = $signed(b);
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Start one operation, scramble the inputs after acceptance, and observe completion
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat,
                       output int pulses, output int strobe_bad, output int hold_bad);
    int cyc;
    hi = '0; lo = '0; lat = -1; pulses = 0; strobe_bad = 0; hold_bad = 0;
    @(negedge clk);
    start = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk);
    start = 1'b0; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
    cyc = 1;
    while (cyc < 80 && !(pulses > 0 && !busy)) begin
      if (done) begin
        if (pulses == 0) begin
          lat = cyc; hi = hi_in; lo = lo_in;
        end
        pulses++;
      end
      if (hi_w !== done || lo_w !== done) strobe_bad++;
      @(negedge clk);
      cyc++;
    end
    repeat (3) begin
      if (hi_in !== hi || lo_in !== lo) hold_bad++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if ({hi_w, lo_w} !== 2'b00) begin errors++; $display("FAIL reset_wr: got %b want 00", {hi_w, lo_w}); end
    checks++; if (hi_in !== '0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi_in); end
    checks++; if (lo_in !== '0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo_in); end
    start = 1'b0;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic test_directed;
    vec_t v[8];
    logic [31:0] hi, lo;
    int lat, pulses, sbad, hbad;
    v[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    v[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    v[2] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    v[3] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[4] = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    v[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    v[6] = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    v[7] = '{2'b10, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF};
    for (int i = 0; i < 8; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, hi, lo, lat, pulses, sbad, hbad);
      checks++; if (hi !== v[i].hi) begin errors++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, v[i].hi); end
      checks++; if (lo !== v[i].lo) begin errors++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, v[i].lo); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL dir%0d_pulses: got %0d want 1", i, pulses); end
      checks++; if (sbad != 0) begin errors++; $display("FAIL dir%0d_strobes: got %0d bad cycles want 0", i, sbad); end
      checks++; if (hbad != 0) begin errors++; $display("FAIL dir%0d_hold: got %0d bad cycles want 0", i, hbad); end
    end
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [63:0] exp;
    int lat, pulses, sbad, hbad;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFFFFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      exp = ref_model(op, a, b);
      do_op(op, a, b, hi, lo, lat, pulses, sbad, hbad);
      checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h_%h want %h", i, op, a, b, hi, lo, exp); end
      checks++; if (lat != LAT || pulses != 1) begin errors++; $display("FAIL rnd%0d_timing: got lat=%0d pulses=%0d want lat=%0d pulses=1", i, lat, pulses, LAT); end
      checks++; if (sbad != 0 || hbad != 0) begin errors++; $display("FAIL rnd%0d_strobe_hold: got %0d/%0d bad cycles want 0/0", i, sbad, hbad); end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1, hi0, lo0;
    logic [63:0] exp0, exp1;
    int pulses, busy_gaps, lat0, cyc;
    op0 = 2'b00; a0 = $urandom; b0 = $urandom;
    exp0 = ref_model(op0, a0, b0);
    hi0 = '0; lo0 = '0; pulses = 0; busy_gaps = 0; lat0 = -1;
    @(negedge clk);
    start = 1'b1; op_i = op0; a_i = a0; b_i = b0;
    cyc = 0;
    // Keep start high with fresh operands until the unit is idle again
    do begin
      @(negedge clk);
      cyc++;
      op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
      if (done) begin
        pulses++; lat0 = cyc; hi0 = hi_in; lo0 = lo_in;
      end
      if (busy) begin end else busy_gaps++;
    end while (busy && cyc < 80);
    op1 = op_i; a1 = a_i; b1 = b_i;
    exp1 = ref_model(op1, a1, b1);
    checks++; if ({hi0, lo0} !== exp0) begin errors++; $display("FAIL b2b_first_result: got %h_%h want %h", hi0, lo0, exp0); end
    checks++; if (pulses != 1 || lat0 != LAT) begin errors++; $display("FAIL b2b_first_done: got pulses=%0d lat=%0d want 1/%0d", pulses, lat0, LAT); end
    checks++; if (cyc != LAT + 1 || busy_gaps != 1) begin errors++; $display("FAIL b2b_idle_point: got cyc=%0d gaps=%0d want %0d/1", cyc, busy_gaps, LAT + 1); end
    @(negedge clk);
    start = 1'b0; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got busy=%b want 1", busy); end
    cyc = 1;
    while (!done && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc != LAT || {hi_in, lo_in} !== exp1) begin errors++; $display("FAIL b2b_second_result: got lat=%0d %h_%h want lat=%0d %h", cyc, hi_in, lo_in, LAT, exp1); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] hi, lo;
    int lat, pulses, sbad, hbad, stray;
    stray = 0;
    @(negedge clk);
    start = 1'b1; op_i = 2'b01; a_i = $urandom | 32'h1; b_i = $urandom | 32'h1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin
      if (done) stray++;
      @(negedge clk);
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if ({done, hi_w, lo_w} !== 3'b000) begin errors++; $display("FAIL midrst_strobes: got %b want 000", {done, hi_w, lo_w}); end
    checks++; if ({hi_in, lo_in} !== 64'h0) begin errors++; $display("FAIL midrst_outputs: got %h_%h want 0", hi_in, lo_in); end
    checks++; if (stray != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", stray); end
    do_op(2'b01, 32'd6, 32'd7, hi, lo, lat, pulses, sbad, hbad);
    checks++; if (hi !== 32'd0 || lo !== 32'd42) begin errors++; $display("FAIL midrst_next_op: got %h_%h want 0_2a", hi, lo); end
    checks++; if (lat != LAT || pulses != 1) begin errors++; $display("FAIL midrst_next_timing: got lat=%0d pulses=%0d want %0d/1", lat, pulses, LAT); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
